// File: rtl/trace_monitor.sv
// trace_monitor
//   Captures the program counter whenever any enabled trigger channel fires.
//   Each entry holds the PC, a cycle-count timestamp and the index of the
//   lowest asserted trigger channel. Entries go into a first-word-fall-through
//   FIFO, so the oldest entry is always presented on rd_*. A free-running
//   cycle counter drives a sticky timeout flag.
//
// Parameters
//   XLEN       width of the captured PC
//   DEPTH      FIFO entries (power of 2, >= 2)
//   NUM_TRIG   number of trigger channels (>= 1)
//   TS_WIDTH   timestamp / cycle counter width
//   MAX_CYCLES cycle count at which timeout sets
//   MODE       0 = drop new captures when full, 1 = overwrite oldest entry
//
// Ports
//   clk, rst   clock and synchronous active-high reset (highest priority)
//   en, clr    capture enable; synchronous clear of FIFO, flags and counter
//   trig, pc   per-channel trigger strobes and the PC sampled on capture
//   rd_en      pop the head entry (ignored while empty)
//   rd_valid, rd_pc, rd_ts, rd_src   head entry, valid while non-empty
//   count      occupancy 0..DEPTH
//   overflow   sticky: a capture was dropped or an entry overwritten
//   cycle_cnt, timeout   free-running counter and sticky timeout flag
module trace_monitor #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_TRIG   = 2,
  parameter int unsigned TS_WIDTH   = 32,
  parameter int unsigned MAX_CYCLES = 200000,
  parameter int unsigned MODE       = 0,
  localparam int unsigned SRC_W     = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic [NUM_TRIG-1:0] trig,
  input  logic [XLEN-1:0]     pc,
  input  logic                rd_en,
  output logic                rd_valid,
  output logic [XLEN-1:0]     rd_pc,
  output logic [TS_WIDTH-1:0] rd_ts,
  output logic [SRC_W-1:0]    rd_src,
  output logic [CNT_W-1:0]    count,
  output logic                overflow,
  output logic [TS_WIDTH-1:0] cycle_cnt,
  output logic                timeout
);

  localparam logic [TS_WIDTH-1:0] LAST_CYCLE = TS_WIDTH'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]    FULL_CNT   = CNT_W'(DEPTH);

  // Entry storage; not reset, since the pointers and count define validity.
  logic [XLEN-1:0]     pc_mem_q  [DEPTH];
  logic [TS_WIDTH-1:0] ts_mem_q  [DEPTH];
  logic [SRC_W-1:0]    src_mem_q [DEPTH];

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [TS_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic                timeout_q, timeout_d;

  logic                capture;
  logic                pop;
  logic                full;
  logic                mem_we;
  logic [SRC_W-1:0]    src_sel;

  // Lowest-index asserted trigger wins: scan from the top down so the
  // lowest set bit is the last assignment.
  always_comb begin
    src_sel = '0;
    for (int unsigned i = NUM_TRIG; i > 0; i--) begin
      if (trig[i-1]) src_sel = SRC_W'(i - 1);
    end
  end

  always_comb begin
    capture     = en && (|trig);
    full        = (count_q == FULL_CNT);
    pop         = rd_en && (count_q != '0);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    mem_we      = 1'b0;
    cycle_cnt_d = cycle_cnt_q + TS_WIDTH'(1);
    timeout_d   = timeout_q || (cycle_cnt_q == LAST_CYCLE);

    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      cycle_cnt_d = '0;
      timeout_d   = 1'b0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      if (capture) begin
        if (!full || pop) begin
          // When full with a pop, wr_ptr equals the old head slot, which the
          // pop frees this same edge: pop-then-store without losing order.
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else if (MODE == 1) begin
          // Overwrite the oldest entry and advance the head past it.
          mem_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + PTR_W'(1);
          rd_ptr_d   = rd_ptr_q + PTR_W'(1);
          overflow_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end

      if (capture && !full && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !capture) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      cycle_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      cycle_cnt_q <= cycle_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      pc_mem_q[wr_ptr_q]  <= pc;
      ts_mem_q[wr_ptr_q]  <= cycle_cnt_q;
      src_mem_q[wr_ptr_q] <= src_sel;
    end
  end

  assign rd_valid  = (count_q != '0);
  assign rd_pc     = pc_mem_q[rd_ptr_q];
  assign rd_ts     = ts_mem_q[rd_ptr_q];
  assign rd_src    = src_mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign cycle_cnt = cycle_cnt_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_trace_monitor.sv
// Testbench for trace_monitor: two instances (drop-when-full and
// overwrite-oldest) share one stimulus stream and are compared against a
// queue-based reference model plus directed expectations.
module tb_trace_monitor;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned NUM_TRIG   = 2;
  localparam int unsigned TS_WIDTH   = 8;
  localparam int unsigned MAX_CYCLES = 10;
  localparam int unsigned CNT_W      = 3;

  typedef struct {
    logic [XLEN-1:0]     pc;
    logic [TS_WIDTH-1:0] ts;
    logic                src;
  } entry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, clr, en, rd_en;
  logic [NUM_TRIG-1:0] trig;
  logic [XLEN-1:0]     pc;

  logic                rd_valid  [2];
  logic [XLEN-1:0]     rd_pc     [2];
  logic [TS_WIDTH-1:0] rd_ts     [2];
  logic                rd_src    [2];
  logic [CNT_W-1:0]    count     [2];
  logic                overflow  [2];
  logic [TS_WIDTH-1:0] cycle_cnt [2];
  logic                timeout   [2];

  int errors = 0;
  int checks = 0;

  // Reference model state
  entry_t mq [2][$];
  bit     m_ovf [2];
  int     m_cyc;
  bit     m_to;

  trace_monitor #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_TRIG(NUM_TRIG), .TS_WIDTH(TS_WIDTH),
                  .MAX_CYCLES(MAX_CYCLES), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig), .pc(pc), .rd_en(rd_en),
    .rd_valid(rd_valid[0]), .rd_pc(rd_pc[0]), .rd_ts(rd_ts[0]), .rd_src(rd_src[0]),
    .count(count[0]), .overflow(overflow[0]), .cycle_cnt(cycle_cnt[0]), .timeout(timeout[0]));

  trace_monitor #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_TRIG(NUM_TRIG), .TS_WIDTH(TS_WIDTH),
                  .MAX_CYCLES(MAX_CYCLES), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig), .pc(pc), .rd_en(rd_en),
    .rd_valid(rd_valid[1]), .rd_pc(rd_pc[1]), .rd_ts(rd_ts[1]), .rd_src(rd_src[1]),
    .count(count[1]), .overflow(overflow[1]), .cycle_cnt(cycle_cnt[1]), .timeout(timeout[1]));

  // Behavioural model: a queue per mode, updated with the inputs seen at the edge.
  task automatic model_step();
    entry_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst || clr) begin
        mq[d].delete();
        m_ovf[d] = 1'b0;
      end else begin
        if (rd_en && mq[d].size() > 0) void'(mq[d].pop_front());
        if (en && trig != '0) begin
          e.pc  = pc;
          e.ts  = TS_WIDTH'(m_cyc);
          e.src = 1'b0;
          for (int b = NUM_TRIG - 1; b >= 0; b--) if (trig[b]) e.src = b[0];
          if (mq[d].size() < int'(DEPTH)) begin
            mq[d].push_back(e);
          end else begin
            m_ovf[d] = 1'b1;
            if (d == 1) begin
              void'(mq[d].pop_front());
              mq[d].push_back(e);
            end
          end
        end
      end
    end
    if (rst || clr) begin
      m_cyc = 0;
      m_to  = 1'b0;
    end else begin
      if (m_cyc == int'(MAX_CYCLES) - 1) m_to = 1'b1;
      m_cyc = (m_cyc + 1) % (1 << TS_WIDTH);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; en = 1'b0; trig = '0; rd_en = 1'b0; pc = '0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic capture(input logic [XLEN-1:0] p, input logic [NUM_TRIG-1:0] t, input logic pop_too);
    en = 1'b1; trig = t; pc = p; rd_en = pop_too;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (count[d] !== 3'd0 || rd_valid[d] !== 1'b0 || overflow[d] !== 1'b0 ||
          timeout[d] !== 1'b0 || cycle_cnt[d] !== 8'd0)
        $display("FAIL reset[%0d]: got cnt=%0d v=%0b ovf=%0b to=%0b cyc=%0d want all 0",
                 d, count[d], rd_valid[d], overflow[d], timeout[d], cycle_cnt[d]);
      if (count[d] !== 3'd0 || rd_valid[d] !== 1'b0 || overflow[d] !== 1'b0 ||
          timeout[d] !== 1'b0 || cycle_cnt[d] !== 8'd0) errors++;
    end
  endtask

  task automatic test_first_capture();
    rst = 1'b0;
    repeat (5) step();
    capture(32'h100, 2'b01, 1'b0);
    checks++;
    if (rd_valid[0] !== 1'b1 || rd_pc[0] !== 32'h100 || rd_ts[0] !== 8'd5 ||
        rd_src[0] !== 1'b0 || count[0] !== 3'd1) begin
      errors++;
      $display("FAIL first_capture: got v=%0b pc=%0h ts=%0d src=%0d cnt=%0d want 1 100 5 0 1",
               rd_valid[0], rd_pc[0], rd_ts[0], rd_src[0], count[0]);
    end
  endtask

  task automatic test_priority();
    do_clear();
    capture(32'h200, 2'b11, 1'b0);
    checks++;
    if (rd_src[0] !== 1'b0 || rd_pc[0] !== 32'h200) begin
      errors++;
      $display("FAIL prio_11: got src=%0d pc=%0h want 0 200", rd_src[0], rd_pc[0]);
    end
    // Capture while popping a non-full FIFO: count unchanged, new entry at head.
    capture(32'h300, 2'b10, 1'b1);
    checks++;
    if (rd_src[0] !== 1'b1 || rd_pc[0] !== 32'h300 || count[0] !== 3'd1) begin
      errors++;
      $display("FAIL prio_10: got src=%0d pc=%0h cnt=%0d want 1 300 1", rd_src[0], rd_pc[0], count[0]);
    end
  endtask

  task automatic test_overflow_modes();
    do_clear();
    for (int i = 1; i <= 5; i++) capture(XLEN'(i), 2'b01, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (count[d] !== 3'd4 || overflow[d] !== 1'b1) begin
        errors++;
        $display("FAIL ovf_full[%0d]: got cnt=%0d ovf=%0b want 4 1", d, count[d], overflow[d]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_pc[0] !== XLEN'(k + 1) || rd_pc[1] !== XLEN'(k + 2)) begin
        errors++;
        $display("FAIL ovf_pop%0d: got m0=%0d m1=%0d want %0d %0d", k, rd_pc[0], rd_pc[1], k + 1, k + 2);
      end
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    checks++;
    if (rd_valid[0] !== 1'b0 || rd_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drained: got v0=%0b v1=%0b want 0 0", rd_valid[0], rd_valid[1]);
    end
  endtask

  task automatic test_full_pop();
    do_clear();
    for (int i = 0; i < 4; i++) capture(32'h10 + XLEN'(i), 2'b01, 1'b0);
    capture(32'h14, 2'b10, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (count[d] !== 3'd4 || overflow[d] !== 1'b0 || rd_pc[d] !== 32'h11) begin
        errors++;
        $display("FAIL full_pop[%0d]: got cnt=%0d ovf=%0b head=%0h want 4 0 11",
                 d, count[d], overflow[d], rd_pc[d]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_pc[0] !== 32'h11 + XLEN'(k) || rd_pc[1] !== 32'h11 + XLEN'(k)) begin
        errors++;
        $display("FAIL full_drain%0d: got %0h %0h want %0h", k, rd_pc[0], rd_pc[1], 32'h11 + k);
      end
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++;
    if (count[0] !== 3'd0 || rd_valid[0] !== 1'b0 || overflow[0] !== 1'b0) begin
      errors++;
      $display("FAIL empty_pop: got cnt=%0d v=%0b ovf=%0b want 0 0 0", count[0], rd_valid[0], overflow[0]);
    end
  endtask

  task automatic test_empty_capture_pop();
    do_clear();
    capture(32'h55, 2'b01, 1'b1);
    checks++;
    if (count[0] !== 3'd1 || rd_pc[0] !== 32'h55) begin
      errors++;
      $display("FAIL empty_cap_pop: got cnt=%0d pc=%0h want 1 55", count[0], rd_pc[0]);
    end
    clr = 1'b1; en = 1'b1; trig = 2'b01; pc = 32'h66; rd_en = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (count[0] !== 3'd0 || count[1] !== 3'd0 || rd_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL clr_prio: got cnt0=%0d cnt1=%0d v=%0b want 0 0 0", count[0], count[1], rd_valid[0]);
    end
  endtask

  task automatic test_timeout();
    do_clear();
    checks++;
    if (cycle_cnt[0] !== 8'd0 || timeout[0] !== 1'b0) begin
      errors++;
      $display("FAIL to_start: got cyc=%0d to=%0b want 0 0", cycle_cnt[0], timeout[0]);
    end
    for (int k = 1; k <= 300; k++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (cycle_cnt[d] !== 8'(k % 256) || timeout[d] !== (k >= int'(MAX_CYCLES))) begin
          errors++;
          $display("FAIL timeout_k%0d[%0d]: got cyc=%0d to=%0b want %0d %0b",
                   k, d, cycle_cnt[d], timeout[d], k % 256, k >= int'(MAX_CYCLES));
        end
      end
    end
    do_clear();
    checks++;
    if (cycle_cnt[0] !== 8'd0 || timeout[0] !== 1'b0) begin
      errors++;
      $display("FAIL to_clr: got cyc=%0d to=%0b want 0 0", cycle_cnt[0], timeout[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_clear();
    for (int i = 0; i < 3; i++) capture(32'h70 + XLEN'(i), 2'b10, 1'b0);
    rst = 1'b1;
    step();
    checks++;
    if (count[0] !== 3'd0 || rd_valid[0] !== 1'b0 || count[1] !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid: got cnt0=%0d v=%0b cnt1=%0d want 0 0 0", count[0], rd_valid[0], count[1]);
    end
    rst = 1'b0;
    repeat (7) step();
    capture(32'hABC, 2'b01, 1'b0);
    checks++;
    if (rd_ts[0] !== 8'd7 || rd_pc[0] !== 32'hABC || count[0] !== 3'd1) begin
      errors++;
      $display("FAIL rst_ts: got ts=%0d pc=%0h cnt=%0d want 7 abc 1", rd_ts[0], rd_pc[0], count[0]);
    end
  endtask

  task automatic test_random();
    int unsigned rd_pct;
    for (int n = 0; n < 1500; n++) begin
      rd_pct = (n < 750) ? 25 : 70;
      rst   = ($urandom_range(199) == 0);
      clr   = ($urandom_range(99) == 0);
      en    = ($urandom_range(99) < 75);
      trig  = NUM_TRIG'($urandom);
      rd_en = ($urandom_range(99) < rd_pct);
      pc    = $urandom;
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (count[d] !== CNT_W'(mq[d].size()) || rd_valid[d] !== (mq[d].size() != 0) ||
            overflow[d] !== m_ovf[d]) begin
          errors++;
          $display("FAIL rand_state[%0d] n=%0d: got cnt=%0d v=%0b ovf=%0b want %0d %0b %0b",
                   d, n, count[d], rd_valid[d], overflow[d], mq[d].size(), mq[d].size() != 0, m_ovf[d]);
        end
        if (mq[d].size() != 0) begin
          checks++;
          if (rd_pc[d] !== mq[d][0].pc || rd_ts[d] !== mq[d][0].ts || rd_src[d] !== mq[d][0].src) begin
            errors++;
            $display("FAIL rand_head[%0d] n=%0d: got pc=%0h ts=%0d src=%0d want %0h %0d %0d",
                     d, n, rd_pc[d], rd_ts[d], rd_src[d], mq[d][0].pc, mq[d][0].ts, mq[d][0].src);
          end
        end
        checks++;
        if (cycle_cnt[d] !== TS_WIDTH'(m_cyc) || timeout[d] !== m_to) begin
          errors++;
          $display("FAIL rand_cyc[%0d] n=%0d: got cyc=%0d to=%0b want %0d %0b",
                   d, n, cycle_cnt[d], timeout[d], m_cyc, m_to);
        end
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_cyc = 0;
    m_to  = 1'b0;
    test_reset();
    test_first_capture();
    test_priority();
    test_overflow_modes();
    test_full_pop();
    test_empty_capture_pop();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trace_monitor.md
TRACE_MONITOR -- requirements
Module: trace_monitor

Interface
REQ-001 Parameter XLEN, default 32: width of captured PC.
REQ-002 Parameter DEPTH, default 16: trace FIFO entries; power of 2, minimum 2.
REQ-003 Parameter NUM_TRIG, default 2: number of independent trigger channels; minimum 1.
REQ-004 Parameter TS_WIDTH, default 32: timestamp and cycle counter width.
REQ-005 Parameter MAX_CYCLES, default 200000: cycle count at which timeout asserts.
REQ-006 Parameter MODE, default 0: 0 = stop-when-full; 1 = overwrite-oldest.
REQ-007 clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 en  input  1  capture enable.
REQ-010 clr  input  1  synchronous clear of FIFO, flags and cycle counter.
REQ-011 trig  input  NUM_TRIG  per-channel trigger strobes, e.g. channel 0 = FENCE decoded.
REQ-012 pc  input  XLEN  program counter sampled on trigger.
REQ-013 rd_en  input  1  pop request for head entry.
REQ-014 rd_valid  output  1  FIFO non-empty; rd_* fields are valid.
REQ-015 rd_pc  output  XLEN  head entry PC.
REQ-016 rd_ts  output  TS_WIDTH  head entry timestamp.
REQ-017 rd_src  output  max(1,clog2(NUM_TRIG))  head entry trigger channel index.
REQ-018 count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-019 overflow  output  1  sticky: at least one capture dropped or one entry overwritten.
REQ-020 cycle_cnt  output  TS_WIDTH  free-running cycle count.
REQ-021 timeout  output  1  sticky: cycle_cnt has reached MAX_CYCLES.

Function
REQ-022 cycle_cnt SHALL increment by 1 each cycle not in rst/clr, wrapping modulo 2^TS_WIDTH.
REQ-023 timeout SHALL set on the edge where cycle_cnt == MAX_CYCLES-1 increments, and stay set until rst/clr, including after cycle_cnt wraps.
REQ-024 Capture event SHALL be en && |trig; at most one entry captured per cycle.
REQ-025 Captured entry SHALL hold pc, the pre-increment cycle_cnt of that cycle, and the lowest-index asserted trig bit as rd_src.
REQ-026 FIFO SHALL be first-word-fall-through: an entry captured at edge N appears on rd_* and in count from edge N onward (visible cycle N+1) if the FIFO was empty.
REQ-027 rd_valid SHALL equal (count != 0); rd_* hold the oldest entry; rd_* are don't-care when rd_valid=0.
REQ-028 rd_en && rd_valid SHALL remove the head entry at the edge; rd_en while empty SHALL be ignored without error.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 Simultaneous capture and pop, not full: count unchanged, FIFO order preserved.
REQ-031 Simultaneous capture and pop while full: pop then store, count stays DEPTH, overflow unchanged, both modes.
REQ-032 Simultaneous capture and rd_en while empty: entry stored, pop ignored, count becomes 1.
REQ-033 MODE 0, capture while full without pop: entry discarded, contents unchanged, overflow set.
REQ-034 MODE 1, capture while full without pop: oldest entry discarded, new entry appended, count stays DEPTH, overflow set.
REQ-035 clr SHALL take priority over capture and pop in the same cycle; that cycle's capture is not stored.

Reset
REQ-036 rst SHALL take priority over clr and all other inputs.
REQ-037 On rst or clr: count=0, rd_valid=0, overflow=0, timeout=0, cycle_cnt=0, pointers=0; FIFO storage need not be cleared.
REQ-038 Reset mid-operation SHALL discard all entries; the first post-reset capture reads back with ts equal to cycles elapsed since reset release.

Verification
REQ-039 Release rst, wait 5 cycles, pulse trig=2'b01, pc=0x00000100 -> next cycle rd_valid=1, rd_pc=0x100, rd_ts=5, rd_src=0, count=1.
REQ-040 trig=2'b11 with pc=0x200 -> rd_src=0; trig=2'b10 -> rd_src=1.
REQ-041 MODE 0, DEPTH 4, 5 captures with pc 1..5 -> count=4, overflow=1, pops return 1,2,3,4, then rd_valid=0.
REQ-042 MODE 1, DEPTH 4, 5 captures with pc 1..5 -> count=4, overflow=1, pops return 2,3,4,5.
REQ-043 Full FIFO, capture and rd_en same cycle -> count stays 4, overflow stays 0, order preserved; rd_en while empty -> no change.
REQ-044 MAX_CYCLES=10: timeout=0 through cycle 9, 1 from cycle 10; clr -> timeout=0, cycle_cnt=0; rst asserted with 3 entries -> count=0 next cycle.
